// File: rtl/cdc_rd_elastic_buf.sv
// -----------------------------------------------------------------------------
// cdc_rd_elastic_buf
//
// Read-domain elastic buffer that sits directly behind the CDC handshake block
// in the rclk domain. Words offered on the handshake's read side
// (rd_vld/rd_rdy) are stored in a small circular array and presented
// first-word-fall-through to the local consumer. Consumer back-pressure is
// therefore absorbed here instead of stalling the synchronizer loop. A
// protocol checker watches the upstream valid/ready contract and raises a
// sticky error flag.
//
// Optional feature macro: CDC_RD_BUF_STATS_EN
//   defined   -> xfer_cnt counts output transfers (wraps at 16 bits)
//   undefined -> counter compiled out, xfer_cnt tied to 16'h0000
//
// Parameters
//   DW     data width in bits
//   DEPTH  number of entries (power of two, >= 2)
//   AW     pointer index width, derived from DEPTH
//
// Ports
//   rclk      in   read-domain clock, rising edge
//   rd_rst    in   asynchronous active-high reset
//   rd_vld    in   upstream word valid
//   rd_data   in   upstream word
//   rd_rdy    out  buffer can accept a word
//   out_vld   out  head word valid
//   out_data  out  head word (FWFT)
//   out_rdy   in   consumer accepts the head word
//   level     out  stored entry count, 0..DEPTH
//   proto_err out  sticky upstream protocol violation
//   xfer_cnt  out  output transfer count
// -----------------------------------------------------------------------------
module cdc_rd_elastic_buf #(
    parameter int  DW    = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          rclk,
    input  logic          rd_rst,
    input  logic          rd_vld,
    input  logic [DW-1:0] rd_data,
    output logic          rd_rdy,
    output logic          out_vld,
    output logic [DW-1:0] out_data,
    input  logic          out_rdy,
    output logic [AW:0]   level,
    output logic          proto_err,
    output logic [15:0]   xfer_cnt
);

    // Pointer increment constant sized to the pointer width.
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Storage and pointers. The pointer MSB is the wrap bit that separates
    // full from empty when the indices match.
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   wptr_d;
    logic [AW:0]   rptr_q;
    logic [AW:0]   rptr_d;

    // Held low through reset and for the cycle it is released, so rd_rdy
    // first rises on the first rclk edge after rd_rst deasserts.
    logic          rdy_en_q;
    logic          rdy_en_d;

    // Protocol checker history: previous cycle stalled, and its data.
    logic          stall_q;
    logic          stall_d;
    logic [DW-1:0] hold_data_q;
    logic [DW-1:0] hold_data_d;
    logic          proto_err_q;
    logic          proto_err_d;

    // Decoded status and transfer strobes.
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          viol_s;
    logic [AW-1:0] widx_s;
    logic [AW-1:0] ridx_s;

    // Status decode: uses only pointer/enable flops, so rd_rdy and out_vld
    // have no combinational path from rd_vld or out_rdy.
    always_comb begin
        widx_s  = wptr_q[AW-1:0];
        ridx_s  = rptr_q[AW-1:0];
        empty_s = (wptr_q == rptr_q);
        full_s  = (wptr_q[AW] != rptr_q[AW]) && (widx_s == ridx_s);
        rd_rdy  = rdy_en_q && !full_s;
        out_vld = !empty_s;
        level   = wptr_q - rptr_q;
    end

    // Handshake strobes for this cycle.
    always_comb begin
        push_s = rd_vld && rd_rdy;
        pop_s  = out_vld && out_rdy;
    end

    // FWFT head read. The head is forced to zero while empty so that stale
    // or never-written entries are not exposed after reset.
    always_comb begin
        if (empty_s) begin
            out_data = {DW{1'b0}};
        end else begin
            out_data = mem_q[ridx_s];
        end
    end

    // Pointer next-state: each pointer advances on its own transfer and
    // wraps naturally through the MSB.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rdy_en_d = 1'b1;
        if (push_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer and ready-enable registers.
    always_ff @(posedge rclk or posedge rd_rst) begin
        if (rd_rst) begin
            wptr_q   <= {(AW+1){1'b0}};
            rptr_q   <= {(AW+1){1'b0}};
            rdy_en_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    // Storage array write. Contents are not reset; they are unreachable
    // once the pointers clear.
    always_ff @(posedge rclk) begin
        if (push_s) begin
            mem_q[widx_s] <= rd_data;
        end
    end

    // Protocol check: once a word has been offered and not taken, the
    // producer must keep rd_vld high with unchanged data until accepted.
    // The checker only observes; it never gates push_s.
    always_comb begin
        stall_d     = rd_vld && !rd_rdy;
        hold_data_d = rd_data;
        if (stall_q && (!rd_vld || (rd_data != hold_data_q))) begin
            viol_s = 1'b1;
        end else begin
            viol_s = 1'b0;
        end
        proto_err_d = proto_err_q || viol_s;
    end

    // Protocol checker registers; the error flag is sticky until reset.
    always_ff @(posedge rclk or posedge rd_rst) begin
        if (rd_rst) begin
            stall_q     <= 1'b0;
            hold_data_q <= {DW{1'b0}};
            proto_err_q <= 1'b0;
        end else begin
            stall_q     <= stall_d;
            hold_data_q <= hold_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Sticky error output straight from its flop.
    always_comb begin
        proto_err = proto_err_q;
    end

`ifdef CDC_RD_BUF_STATS_EN
    logic [15:0] xfer_cnt_q;
    logic [15:0] xfer_cnt_d;

    // Output transfer counter next-state; wraps from 16'hFFFF to 16'h0000.
    always_comb begin
        if (pop_s) begin
            xfer_cnt_d = xfer_cnt_q + 16'h0001;
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
    end

    // Output transfer counter register.
    always_ff @(posedge rclk or posedge rd_rst) begin
        if (rd_rst) begin
            xfer_cnt_q <= 16'h0000;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    // Counter output straight from its flop.
    always_comb begin
        xfer_cnt = xfer_cnt_q;
    end
`else
    // Statistics disabled: the port stays but reads as zero.
    always_comb begin
        xfer_cnt = 16'h0000;
    end
`endif

endmodule

// File: tb/tb_cdc_rd_elastic_buf.sv
// -----------------------------------------------------------------------------
// Testbench for cdc_rd_elastic_buf (DW=8, DEPTH=4).
// A queue model tracks stored words and predicts rd_rdy/out_vld/level; a
// table of hand-computed vectors covers fill and drain, and hand-written
// sequences cover streaming, protocol errors and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_cdc_rd_elastic_buf;

    logic        rclk;
    logic        rd_rst;
    logic        rd_vld;
    logic [7:0]  rd_data;
    logic        rd_rdy;
    logic        out_vld;
    logic [7:0]  out_data;
    logic        out_rdy;
    logic [2:0]  level;
    logic        proto_err;
    logic [15:0] xfer_cnt;

    cdc_rd_elastic_buf #(.DW(8), .DEPTH(4)) dut (
        .rclk      (rclk),
        .rd_rst    (rd_rst),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .rd_rdy    (rd_rdy),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .level     (level),
        .proto_err (proto_err),
        .xfer_cnt  (xfer_cnt)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    int n_vec;
    int n_err;

    // Reference model state
    logic [7:0]  q_m[$];
    logic        m_rdy_en;
    logic        m_stall;
    logic [7:0]  m_sdata;
    logic        m_perr;
    logic [15:0] m_cnt;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       ordy;
        logic [2:0] exp_level;
        logic       exp_rdy;
        logic       exp_ovld;
        logic [7:0] exp_head;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        m_rdy_en = 1'b0;
        m_stall  = 1'b0;
        m_sdata  = 8'h00;
        m_perr   = 1'b0;
        m_cnt    = 16'h0000;
    endtask

    // Called at posedge+1; drives one cycle, checks pre-edge outputs and
    // the head word, then checks post-edge state at the next posedge+1.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic r);
        logic m_rdy;
        logic m_ovld;
        logic push;
        logic pop;
        logic viol;
        rd_vld  = v;
        rd_data = d;
        out_rdy = r;
        #1;
        m_rdy  = m_rdy_en && (q_m.size() < 4);
        m_ovld = (q_m.size() != 0);
        check("rd_rdy", {31'd0, rd_rdy}, {31'd0, m_rdy});
        check("out_vld", {31'd0, out_vld}, {31'd0, m_ovld});
        if (m_ovld) begin
            check("head_data", {24'd0, out_data}, {24'd0, q_m[0]});
        end
        push = v && m_rdy;
        pop  = m_ovld && r;
        viol = m_stall && (!v || (d != m_sdata));
        @(posedge rclk);
        #1;
        if (pop) begin
            void'(q_m.pop_front());
`ifdef CDC_RD_BUF_STATS_EN
            m_cnt = m_cnt + 16'h0001;
`endif
        end
        if (push) begin
            q_m.push_back(d);
        end
        m_stall  = v && !m_rdy;
        m_sdata  = d;
        m_perr   = m_perr || viol;
        m_rdy_en = 1'b1;
        check("level", {29'd0, level}, q_m.size());
        check("proto_err", {31'd0, proto_err}, {31'd0, m_perr});
        check("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, m_cnt});
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rd_rst  = 1'b0;
        rd_vld  = 1'b0;
        rd_data = 8'h00;
        out_rdy = 1'b0;
        model_reset();

        // Fill then drain, expectations computed by hand.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b1, 8'h11};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 1'b1, 8'h11};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 1'b1, 8'h11};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b0, 1'b1, 8'h11};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 8'h22};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 8'h33};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 8'h44};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00};

        // Reset state and release.
        #1 rd_rst = 1'b1;
        #1;
        check("rst_out_vld", {31'd0, out_vld}, 32'd0);
        check("rst_rd_rdy", {31'd0, rd_rdy}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
        #10 rd_rst = 1'b0;
        #1;
        check("rdy_before_edge", {31'd0, rd_rdy}, 32'd0);
        @(posedge rclk);
        #1;
        m_rdy_en = 1'b1;
        check("rdy_after_edge", {31'd0, rd_rdy}, 32'd1);
        check("ovld_after_rel", {31'd0, out_vld}, 32'd0);
        check("level_after_rel", {29'd0, level}, 32'd0);

        // Table: fill to full, then drain in order.
        for (int i = 0; i < 8; i++) begin
            drive_cycle(tbl[i].vld, tbl[i].data, tbl[i].ordy);
            check("tbl_level", {29'd0, level}, {29'd0, tbl[i].exp_level});
            check("tbl_rd_rdy", {31'd0, rd_rdy}, {31'd0, tbl[i].exp_rdy});
            check("tbl_out_vld", {31'd0, out_vld}, {31'd0, tbl[i].exp_ovld});
            if (tbl[i].exp_ovld) begin
                check("tbl_head", {24'd0, out_data}, {24'd0, tbl[i].exp_head});
            end
        end
`ifdef CDC_RD_BUF_STATS_EN
        check("xfer_cnt_4", {16'd0, xfer_cnt}, 32'd4);
`else
        check("xfer_cnt_off", {16'd0, xfer_cnt}, 32'd0);
`endif

        // Streaming: push and pop every cycle, pointers wrap 5 times.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] dv;
            dv = 8'h80 + 8'(i);
            drive_cycle(1'b1, dv, 1'b1);
            check("stream_level", {29'd0, level}, 32'd1);
            check("stream_head", {24'd0, out_data}, {24'd0, dv});
        end
        drive_cycle(1'b0, 8'h00, 1'b1);

        // Protocol violation while full; contents must survive.
        drive_cycle(1'b1, 8'hA1, 1'b0);
        drive_cycle(1'b1, 8'hA2, 1'b0);
        drive_cycle(1'b1, 8'hA3, 1'b0);
        drive_cycle(1'b1, 8'hA4, 1'b0);
        drive_cycle(1'b1, 8'h55, 1'b0);
        check("fifth_rejected", {29'd0, level}, 32'd4);
        check("no_err_yet", {31'd0, proto_err}, 32'd0);
        drive_cycle(1'b1, 8'h56, 1'b0);
        check("err_set", {31'd0, proto_err}, 32'd1);
        drive_cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1);
        end
        check("err_sticky", {31'd0, proto_err}, 32'd1);

        // Asynchronous reset with three words stored.
        drive_cycle(1'b1, 8'hC1, 1'b0);
        drive_cycle(1'b1, 8'hC2, 1'b0);
        drive_cycle(1'b1, 8'hC3, 1'b0);
        check("pre_rst_level", {29'd0, level}, 32'd3);
        rd_vld = 1'b0;
        rd_rst = 1'b1;
        #1;
        model_reset();
        check("arst_out_vld", {31'd0, out_vld}, 32'd0);
        check("arst_rd_rdy", {31'd0, rd_rdy}, 32'd0);
        check("arst_level", {29'd0, level}, 32'd0);
        check("arst_proto_err", {31'd0, proto_err}, 32'd0);
        check("arst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
        #2 rd_rst = 1'b0;
        #1;
        check("arst_rdy_low", {31'd0, rd_rdy}, 32'd0);
        @(posedge rclk);
        #1;
        m_rdy_en = 1'b1;
        check("arst_rdy_up", {31'd0, rd_rdy}, 32'd1);
        drive_cycle(1'b1, 8'hD7, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
